// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder.
// Imported by the interface, the timer and the top.
package mem_responder_pkg;

  localparam int PMA_W  = 22;
  localparam int DATA_W = 32;
  localparam int TMR_W  = 8;

  localparam int TIMEOUT_DEF = 255;

  localparam logic [DATA_W-1:0] NXM_DATA = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Write wins when both strobes are raised together.
  function automatic logic req_is_write(
    input logic rd,
    input logic wr
  );
    req_is_write = wr | (rd & wr);
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Processor-side and bus-side signals of the responder.
// The slave modport is the responder's view.
interface mem_responder_if;
  import mem_responder_pkg::*;

  logic              memrd;
  logic              memwr;
  logic [PMA_W-1:0]  pma;
  logic [DATA_W-1:0] md;
  logic              membusy;
  logic              memack;
  logic              loadmd;
  logic [DATA_W-1:0] mdout;
  logic              nxm;
  logic              bus_req;
  logic              bus_write;
  logic [PMA_W-1:0]  bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output memrd,
    output memwr,
    output pma,
    output md,
    output bus_ack,
    output bus_rdata,
    input  membusy,
    input  memack,
    input  loadmd,
    input  mdout,
    input  nxm,
    input  bus_req,
    input  bus_write,
    input  bus_addr,
    input  bus_wdata
  );

  modport slave (
    input  memrd,
    input  memwr,
    input  pma,
    input  md,
    input  bus_ack,
    input  bus_rdata,
    output membusy,
    output memack,
    output loadmd,
    output mdout,
    output nxm,
    output bus_req,
    output bus_write,
    output bus_addr,
    output bus_wdata
  );

endinterface

// File: rtl/mem_responder_timer.sv
// Bus-cycle watchdog: counts unanswered BUS cycles.
// expired flags the last allowed cycle, so the count never wraps.
module mem_timer
  import mem_responder_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] cnt;

  assign expired = count && (cnt == LAST);

  // Count waiting cycles; hold at the last value.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (count && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: IDLE -> BUS -> DONE.
// Aborts with nxm when the bus never acknowledges.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic           clk,
  input  logic           reset,
  mem_responder_if.slave mem
);

  state_t state;
  state_t state_nx;

  logic accept;
  logic count;
  logic expired;
  logic ack;

  logic              write_q;
  logic [PMA_W-1:0]  addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              nxm_q;

  logic bus_req_c;
  logic busy_c;
  logic memack_c;
  logic loadmd_c;

  assign accept = (state == ST_IDLE)
                & (mem.memrd | mem.memwr);
  assign ack    = (state == ST_BUS) & mem.bus_ack;
  assign count  = (state == ST_BUS) & ~mem.bus_ack;

  mem_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept),
    .count   (count),
    .expired (expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state: ack or timeout ends BUS; DONE lasts one cycle.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) state_nx = ST_BUS;
      end
      ST_BUS: begin
        if (ack || expired) state_nx = ST_DONE;
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    bus_req_c = 1'b0;
    busy_c    = 1'b0;
    memack_c  = 1'b0;
    loadmd_c  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        busy_c = 1'b0;
      end
      ST_BUS: begin
        bus_req_c = 1'b1;
        busy_c    = 1'b1;
      end
      ST_DONE: begin
        busy_c   = 1'b1;
        memack_c = 1'b1;
        loadmd_c = ~write_q;
      end
      default: begin
        busy_c = 1'b0;
      end
    endcase
  end

  // Request capture at accept; frozen for the whole cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      write_q <= req_is_write(mem.memrd, mem.memwr);
      addr_q  <= mem.pma;
      wdata_q <= mem.md;
    end
  end

  // Completion status: read data and nxm flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
      nxm_q   <= 1'b0;
    end else if (accept) begin
      nxm_q <= 1'b0;
    end else if (ack) begin
      nxm_q <= 1'b0;
      if (!write_q) rdata_q <= mem.bus_rdata;
    end else if (expired) begin
      nxm_q <= 1'b1;
      if (!write_q) rdata_q <= NXM_DATA;
    end
  end

  assign mem.bus_req   = bus_req_c;
  assign mem.membusy   = busy_c;
  assign mem.memack    = memack_c;
  assign mem.loadmd    = loadmd_c;
  assign mem.nxm       = nxm_q;
  assign mem.mdout     = rdata_q;
  assign mem.bus_write = write_q;
  assign mem.bus_addr  = addr_q;
  assign mem.bus_wdata = wdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: transaction model checked every
// cycle plus directed read/write/timeout/reset scenarios.
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic reset;

  mem_responder_if m ();

  mem_responder #(
    .TIMEOUT (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .mem   (m.slave)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Transaction model: one outstanding cycle, counted in
  // BUS cycles; finishes on ack or after TO unanswered cycles.
  bit          started = 0;
  bit          md_cyc  = 0;
  bit          md_done = 0;
  bit          md_wr   = 0;
  bit          md_nxm  = 0;
  int          md_n    = 0;
  logic [21:0] md_addr = '0;
  logic [31:0] md_wd   = '0;
  logic [31:0] md_rd   = '0;

  always @(posedge clk) begin
    if (reset) begin
      started = 1;
      md_cyc  = 0;
      md_done = 0;
      md_wr   = 0;
      md_nxm  = 0;
      md_addr = '0;
      md_wd   = '0;
      md_rd   = '0;
    end else if (md_done) begin
      md_done = 0;
    end else if (md_cyc) begin
      md_n++;
      if (m.bus_ack) begin
        md_cyc  = 0;
        md_done = 1;
        md_nxm  = 0;
        if (!md_wr) md_rd = m.bus_rdata;
      end else if (md_n == TO) begin
        md_cyc  = 0;
        md_done = 1;
        md_nxm  = 1;
        if (!md_wr) md_rd = 32'hFFFF_FFFF;
      end
    end else if (m.memrd || m.memwr) begin
      md_cyc  = 1;
      md_n    = 0;
      md_wr   = m.memwr;
      md_addr = m.pma;
      md_wd   = m.md;
      md_nxm  = 0;
    end
    #1;
    if (started) begin
      chk("m_bus_req", m.bus_req, md_cyc);
      chk("m_busy", m.membusy, md_cyc | md_done);
      chk("m_memack", m.memack, md_done);
      chk("m_loadmd", m.loadmd, md_done & !md_wr);
      chk("m_nxm", m.nxm, md_nxm);
      chk("m_bus_write", m.bus_write, md_wr);
      chk("m_mdout", m.mdout, md_rd);
      chk("m_bus_addr", m.bus_addr, md_addr);
      chk("m_bus_wdata", m.bus_wdata, md_wd);
    end
  end

  int n;
  int k;

  initial begin
    m.memrd     = 0;
    m.memwr     = 0;
    m.pma       = '0;
    m.md        = '0;
    m.bus_ack   = 0;
    m.bus_rdata = '0;
    reset       = 1;
    repeat (3) @(negedge clk);
    chk("rst_busy", m.membusy, 0);
    chk("rst_req", m.bus_req, 0);
    chk("rst_mdout", m.mdout, 0);
    chk("rst_addr", m.bus_addr, 0);
    chk("rst_write", m.bus_write, 0);
    reset = 0;

    // read, ack in first BUS cycle
    m.memrd = 1;
    m.pma   = 22'h001234;
    @(negedge clk);
    chk("rd_req", m.bus_req, 1);
    chk("rd_addr", m.bus_addr, 32'h1234);
    m.memrd     = 0;
    m.bus_ack   = 1;
    m.bus_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("rd_ack", m.memack, 1);
    chk("rd_load", m.loadmd, 1);
    chk("rd_data", m.mdout, 32'hDEADBEEF);
    chk("rd_nxm", m.nxm, 0);
    m.bus_ack = 0;
    @(negedge clk);
    chk("rd_idle", m.membusy, 0);
    chk("rd_hold", m.mdout, 32'hDEADBEEF);

    // write, ack in third BUS cycle; inputs scrambled meanwhile
    m.memwr = 1;
    m.pma   = 22'h3FFFFF;
    m.md    = 32'h0000A5A5;
    @(negedge clk);
    m.memwr = 0;
    m.pma   = '0;
    m.md    = '0;
    for (int i = 0; i < 3; i++) begin
      chk("wr_req", m.bus_req, 1);
      chk("wr_wr", m.bus_write, 1);
      chk("wr_addr", m.bus_addr, 32'h3FFFFF);
      chk("wr_data", m.bus_wdata, 32'hA5A5);
      if (i == 2) m.bus_ack = 1;
      @(negedge clk);
    end
    chk("wr_ack", m.memack, 1);
    chk("wr_load", m.loadmd, 0);
    chk("wr_mdout", m.mdout, 32'hDEADBEEF);
    m.bus_ack = 0;
    @(negedge clk);

    // timeout: no ack at all
    m.memrd = 1;
    m.pma   = 22'h000005;
    @(negedge clk);
    m.memrd = 0;
    n = 0;
    k = 0;
    while (m.memack !== 1'b1 && k < 20) begin
      if (m.bus_req) n++;
      k++;
      @(negedge clk);
    end
    chk("to_seen", k < 20, 1);
    chk("to_reqs", n, 4);
    chk("to_nxm", m.nxm, 1);
    chk("to_data", m.mdout, 32'hFFFFFFFF);
    chk("to_load", m.loadmd, 1);
    @(negedge clk);
    chk("to_nxm_hold", m.nxm, 1);
    chk("to_idle", m.membusy, 0);

    // ack arriving on the would-be timeout cycle
    m.memrd = 1;
    m.pma   = 22'h000006;
    @(negedge clk);
    m.memrd = 0;
    chk("tk_nxm_clr", m.nxm, 0);
    repeat (3) @(negedge clk);
    chk("tk_req4", m.bus_req, 1);
    m.bus_ack   = 1;
    m.bus_rdata = 32'h12345678;
    @(negedge clk);
    chk("tk_ack", m.memack, 1);
    chk("tk_nxm", m.nxm, 0);
    chk("tk_data", m.mdout, 32'h12345678);
    m.bus_ack = 0;
    @(negedge clk);

    // both strobes, second request in BUS, reset in BUS
    m.memrd = 1;
    m.memwr = 1;
    m.pma   = 22'h00002A;
    m.md    = 32'h77;
    @(negedge clk);
    chk("bo_wr", m.bus_write, 1);
    chk("bo_addr", m.bus_addr, 32'h2A);
    m.memwr = 0;
    m.pma   = 22'h000099;
    @(negedge clk);
    chk("bo_addr2", m.bus_addr, 32'h2A);
    chk("bo_req2", m.bus_req, 1);
    reset = 1;
    @(negedge clk);
    chk("bo_rst_req", m.bus_req, 0);
    chk("bo_rst_ack", m.memack, 0);
    chk("bo_rst_busy", m.membusy, 0);
    reset   = 0;
    m.memrd = 0;
    @(negedge clk);
    chk("bo_discard", m.membusy, 0);
    chk("bo_noack", m.memack, 0);

    // normal read after the abandoned cycle
    m.memrd = 1;
    m.pma   = 22'h000ABC;
    @(negedge clk);
    m.memrd     = 0;
    m.bus_ack   = 1;
    m.bus_rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("nx_ack", m.memack, 1);
    chk("nx_data", m.mdout, 32'hCAFEF00D);
    m.bus_ack = 0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the number of BUS-state cycles without bus_ack before a nonexistent-memory abort (legal range 2..255).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port memrd  input  1  processor read request, sampled only in IDLE.
REQ-005 SHALL have port memwr  input  1  processor write request, sampled only in IDLE.
REQ-006 SHALL have port pma  input  22  physical memory address, sampled with the request.
REQ-007 SHALL have port md  input  32  write data, sampled with the request.
REQ-008 SHALL have port membusy  output  1  high from the cycle after accept through the memack cycle.
REQ-009 SHALL have port memack  output  1  one-cycle pulse marking cycle completion.
REQ-010 SHALL have port loadmd  output  1  one-cycle pulse, coincident with memack, on read completion only.
REQ-011 SHALL have port mdout  output  32  read data, valid while loadmd is high and held until the next read completes.
REQ-012 SHALL have port nxm  output  1  high with memack when the cycle timed out, held until the next accept.
REQ-013 SHALL have port bus_req  output  1  bus cycle request.
REQ-014 SHALL have port bus_write  output  1  1 = write cycle, valid while bus_req is high.
REQ-015 SHALL have port bus_addr  output  22  registered pma.
REQ-016 SHALL have port bus_wdata  output  32  registered md.
REQ-017 SHALL have port bus_ack  input  1  bus completion, sampled only in BUS.
REQ-018 SHALL have port bus_rdata  input  32  read data, valid with bus_ack.

Function
REQ-019 SHALL implement the states IDLE, BUS and DONE.
REQ-020 In IDLE, (memrd|memwr)=1 SHALL register pma/md, set bus_write=memwr, clear nxm and the timer, and enter BUS.
REQ-021 memrd and memwr high together SHALL be accepted as a write.
REQ-022 Requests outside IDLE SHALL be ignored: no queueing and no latching.
REQ-023 In BUS, bus_req SHALL be 1; in all other states bus_req SHALL be 0.
REQ-024 In BUS, bus_ack=1 SHALL enter DONE and, on a read, capture bus_rdata into mdout.
REQ-025 In BUS, with no ack, the timer SHALL increment each cycle; when the timer equals TIMEOUT-1, the block SHALL enter DONE with nxm=1 and, on a read, mdout=32'hFFFFFFFF.
REQ-026 bus_ack in the timeout cycle SHALL take priority: normal completion, nxm=0.
REQ-027 In DONE, memack=1 and loadmd=~bus_write; DONE SHALL always return to IDLE after one cycle.
REQ-028 Minimum latency SHALL be: request at edge N, bus_req high in cycle N+1, ack in N+1, memack in N+2, next accept possible at N+3.
REQ-029 membusy SHALL equal (state != IDLE).
REQ-030 bus_addr, bus_wdata and bus_write SHALL be stable for the entire BUS state.
REQ-031 The timer SHALL be 8 bits and SHALL never wrap, because the abort occurs before overflow.

Reset
REQ-032 While reset=1, the state SHALL be IDLE and bus_req, membusy, memack, loadmd and nxm SHALL be 0; bus_write=0; mdout, bus_addr and bus_wdata SHALL be 0; the timer SHALL be 0.
REQ-033 Reset asserted mid-cycle (BUS or DONE) SHALL abandon the cycle with no memack and SHALL drop bus_req at the reset edge.
REQ-034 Requests presented while reset=1 SHALL be discarded.

Structure
REQ-035 A shared package SHALL hold the state enum (IDLE/BUS/DONE), the PMA_W=22 and DATA_W=32 constants, and the TIMEOUT default and NXM_DATA=32'hFFFFFFFF constants.
REQ-036 The timeout counter SHALL be one sub-module, mem_timer (inputs: clear, count; output: expired).

Verification
REQ-037 Read: memrd with pma=22'h001234, bus_ack with bus_rdata=32'hDEADBEEF one cycle later -> memack and loadmd pulse together, mdout=32'hDEADBEEF, nxm=0, 2-cycle latency.
REQ-038 Write: memwr with pma=22'h3FFFFF and md=32'h0000A5A5 -> bus_write=1, bus_addr/bus_wdata hold these values throughout BUS, memack=1 and loadmd=0.
REQ-039 Timeout: read with bus_ack held at 0 and TIMEOUT=4 -> exactly 4 bus_req cycles, then memack=1, nxm=1, mdout=32'hFFFFFFFF.
REQ-040 Ack on the timeout cycle (TIMEOUT=4, ack in the 4th BUS cycle) -> nxm=0 and mdout=bus_rdata.
REQ-041 memrd and memwr both high, a second request during BUS, and reset in the 2nd BUS cycle -> accepted as a write, the second request is ignored, bus_req=0 after the reset edge, no memack, and the next request proceeds normally.
